// File: rtl/rbm_affine_sampler.sv
// RBM hidden-layer sampler: registered affine V*W+b per output plus per-output LFSR Bernoulli bit.
// Define RBM_SAT_EN for full-precision accumulation with saturation; otherwise sums wrap to DATA_W bits.
module rbm_affine_sampler #(
   parameter int          DATA_W    = 12,
   parameter int          IN_DIM    = 6,
   parameter int          OUT_DIM   = 5,
   parameter logic [7:0]  SEED_BASE = 8'h01
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic [IN_DIM*DATA_W-1:0]          image_i,
   input  logic [IN_DIM*OUT_DIM*DATA_W-1:0]  weight_i,
   input  logic [OUT_DIM*DATA_W-1:0]         bias_i,
   output logic [OUT_DIM*DATA_W-1:0]         affine_o,
   output logic [OUT_DIM*8-1:0]              rnd_o,
   output logic [OUT_DIM-1:0]                hout_o,
   output logic                              out_valid
);

   localparam int ACC_W = 2*DATA_W + $clog2(IN_DIM) + 1;

   function automatic logic signed [DATA_W-1:0] affine_elem(
      input int                              j,
      input logic [IN_DIM*DATA_W-1:0]        v_vec,
      input logic [IN_DIM*OUT_DIM*DATA_W-1:0] w_mat,
      input logic [OUT_DIM*DATA_W-1:0]       b_vec
   );
      logic signed [DATA_W-1:0]   v;
      logic signed [DATA_W-1:0]   w;
      logic signed [2*DATA_W-1:0] prod;
`ifdef RBM_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
      localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
      logic signed [ACC_W-1:0]    acc;
      acc = ACC_W'($signed(b_vec[j*DATA_W +: DATA_W]));
      for (int i = 0; i < IN_DIM; i++) begin
         v    = v_vec[i*DATA_W +: DATA_W];
         w    = w_mat[(i*OUT_DIM+j)*DATA_W +: DATA_W];
         prod = v * w;
         acc  = acc + ACC_W'(prod);
      end
      if (acc > SAT_MAX)      affine_elem = SAT_MAX[DATA_W-1:0];
      else if (acc < SAT_MIN) affine_elem = SAT_MIN[DATA_W-1:0];
      else                    affine_elem = acc[DATA_W-1:0];
`else
      logic signed [DATA_W-1:0]   acc;
      acc = b_vec[j*DATA_W +: DATA_W];
      for (int i = 0; i < IN_DIM; i++) begin
         v    = v_vec[i*DATA_W +: DATA_W];
         w    = w_mat[(i*OUT_DIM+j)*DATA_W +: DATA_W];
         prod = v * w;
         acc  = acc + prod[DATA_W-1:0];
      end
      affine_elem = acc;
`endif
   endfunction

   // Clamp the affine result into an 8-bit probability proxy.
   function automatic logic [7:0] prob_of(input logic signed [DATA_W-1:0] a);
      if (a < 0)                          prob_of = 8'h00;
      else if (a > $signed(DATA_W'(255))) prob_of = 8'hFF;
      else                                prob_of = a[7:0];
   endfunction

   function automatic logic [7:0] seed_of(input int j);
      logic [7:0] s;
      s = SEED_BASE + 8'(16*j);
      seed_of = (s == 8'h00) ? 8'h01 : s;
   endfunction

   logic [7:0]                r_lfsr [OUT_DIM];
   logic [OUT_DIM*DATA_W-1:0] r_affine;
   logic [OUT_DIM-1:0]        r_hout;
   logic                      r_valid;
   logic [OUT_DIM*DATA_W-1:0] w_affine;
   logic [OUT_DIM-1:0]        w_hit;

   // NOTE: every output of a combinational block is defaulted first so no path infers a latch.
   always_comb begin
      w_affine = '0;
      w_hit    = '0;
      for (int j = 0; j < OUT_DIM; j++) begin
         w_affine[j*DATA_W +: DATA_W] = affine_elem(j, image_i, weight_i, bias_i);
         w_hit[j] = prob_of(w_affine[j*DATA_W +: DATA_W]) > r_lfsr[j];
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values,
   // which is what lets hout compare against the LFSR state before it advances.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_affine <= '0;
         r_hout   <= '0;
         r_valid  <= 1'b0;
         // NOTE: the LFSR array is a handful of flops, so it is reset element by element to its seeds.
         for (int j = 0; j < OUT_DIM; j++) r_lfsr[j] <= seed_of(j);
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_affine <= w_affine;
            r_hout   <= w_hit;
            for (int j = 0; j < OUT_DIM; j++)
               r_lfsr[j] <= {r_lfsr[j][6:0], r_lfsr[j][7] ^ r_lfsr[j][5] ^ r_lfsr[j][4] ^ r_lfsr[j][3]};
         end
      end
   end

   always_comb begin
      rnd_o = '0;
      for (int j = 0; j < OUT_DIM; j++) rnd_o[j*8 +: 8] = r_lfsr[j];
   end

   assign affine_o  = r_affine;
   assign hout_o    = r_hout;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_rbm_affine_sampler.sv
// Directed self-checking bench for rbm_affine_sampler with hand-derived expectations.
module tb_rbm_affine_sampler;

   localparam int DW = 12;
   localparam int ID = 6;
   localparam int OD = 5;

   logic                  clock;
   logic                  reset;
   logic                  in_valid;
   logic [ID*DW-1:0]      image_i;
   logic [ID*OD*DW-1:0]   weight_i;
   logic [OD*DW-1:0]      bias_i;
   logic [OD*DW-1:0]      affine_o;
   logic [OD*8-1:0]       rnd_o;
   logic [OD-1:0]         hout_o;
   logic                  out_valid;

   int n_checks = 0;
   int n_errors = 0;

   rbm_affine_sampler dut (
      .clock(clock), .reset(reset), .in_valid(in_valid),
      .image_i(image_i), .weight_i(weight_i), .bias_i(bias_i),
      .affine_o(affine_o), .rnd_o(rnd_o), .hout_o(hout_o), .out_valid(out_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
      n_checks++;
      if (obs_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs_v, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [OD*DW-1:0] rep(input logic [DW-1:0] x);
      logic [OD*DW-1:0] r;
      for (int j = 0; j < OD; j++) r[j*DW +: DW] = x;
      return r;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] r);
      return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
   endfunction

   task automatic fill(input logic [DW-1:0] v, input logic [DW-1:0] w, input logic [DW-1:0] b);
      for (int i = 0; i < ID; i++) image_i[i*DW +: DW] = v;
      for (int k = 0; k < ID*OD; k++) weight_i[k*DW +: DW] = w;
      bias_i = rep(b);
   endtask

   logic [7:0]   m_rnd [OD];
   logic [OD*8-1:0] exp_rnd;
   logic [OD-1:0]   exp_h;

   initial begin
      reset = 1'b0; in_valid = 1'b0;
      fill('0, '0, '0);
      #12;
      check("reset_rnd",    64'(rnd_o),    64'h41_31_21_11_01);
      check("reset_affine", 64'(affine_o), 64'h0);
      check("reset_hout",   64'(hout_o),   64'h0);
      check("reset_valid",  64'(out_valid), 64'h0);
      reset = 1'b1;
      step();

      // All-ones operands: a_j = 6, only 6 > seed 0x01 holds.
      fill(12'd1, 12'd1, 12'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("ones_affine", 64'(affine_o), 64'(rep(12'd6)));
      check("ones_hout",   64'(hout_o),   64'h01);
      check("ones_valid",  64'(out_valid), 64'h1);
      check("ones_rnd",    64'(rnd_o),    64'h82_62_43_23_02);
      step();
      check("idle_valid",  64'(out_valid), 64'h0);
      check("idle_affine", 64'(affine_o), 64'(rep(12'd6)));
      check("idle_rnd",    64'(rnd_o),    64'h82_62_43_23_02);

      // Large bias held for 10 cycles: p=255, hout=1 unless LFSR state is FF.
      m_rnd[0] = 8'h02; m_rnd[1] = 8'h23; m_rnd[2] = 8'h43; m_rnd[3] = 8'h62; m_rnd[4] = 8'h82;
      fill(12'd0, 12'd0, 12'd2047);
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         for (int j = 0; j < OD; j++) begin
            exp_h[j] = (8'hFF > m_rnd[j]);
            m_rnd[j] = lfsr_next(m_rnd[j]);
            exp_rnd[j*8 +: 8] = m_rnd[j];
         end
         step();
         check("big_hout",  64'(hout_o),   64'(exp_h));
         check("big_rnd",   64'(rnd_o),    64'(exp_rnd));
         check("big_valid", 64'(out_valid), 64'h1);
      end

      // Negative bias: p=0, never fires.
      fill(12'd0, 12'd0, 12'hFFF);
      for (int c = 0; c < 3; c++) begin
         step();
         check("neg_hout",   64'(hout_o),   64'h0);
         check("neg_affine", 64'(affine_o), 64'(rep(12'hFFF)));
      end
      in_valid = 1'b0;

      // Overflow of a single product.
      fill(12'd0, 12'd0, 12'd0);
      image_i[0 +: DW]  = 12'd2047;
      weight_i[0 +: DW] = 12'd2;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
`ifdef RBM_SAT_EN
      check("ovf_elem0", 64'(affine_o[0 +: DW]), 64'h7FF);
`else
      check("ovf_elem0", 64'(affine_o[0 +: DW]), 64'hFFE);
`endif
      check("ovf_others", 64'(affine_o[OD*DW-1:DW]), 64'h0);

      // Reset mid-stream with in_valid high takes effect between edges.
      fill(12'd1, 12'd1, 12'd5);
      in_valid = 1'b1;
      step();
      #2;
      reset = 1'b0;
      #1;
      check("mid_rnd",    64'(rnd_o),    64'h41_31_21_11_01);
      check("mid_affine", 64'(affine_o), 64'h0);
      check("mid_hout",   64'(hout_o),   64'h0);
      check("mid_valid",  64'(out_valid), 64'h0);
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();

      // Strict compare against seeds: p == seed does not fire, p == next+1 does.
      fill(12'd0, 12'd0, 12'd0);
      bias_i = {12'h041, 12'h031, 12'h021, 12'h011, 12'h001};
      in_valid = 1'b1;
      step();
      check("eq_hout", 64'(hout_o), 64'h00);
      check("eq_rnd",  64'(rnd_o),  64'h82_62_43_23_02);
      bias_i = {12'h083, 12'h063, 12'h044, 12'h024, 12'h003};
      step();
      in_valid = 1'b0;
      check("gt_hout",  64'(hout_o),  64'h1F);
      check("gt_affine", 64'(affine_o), 64'({12'h083, 12'h063, 12'h044, 12'h024, 12'h003}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
